addsub_alu_arbiter: RTL and testbench

- Controller that shares one 4-bit add/sub datapath (the `addsub_4bitmux` unit: 2-bit select `s`, 4-bit operands `a`/`b`, 4-bit result `o`, carry `co`) between two requesters.
- Arbitrates round-robin, latches the winner's op and operands, and holds the datapath inputs stable for a settle window.
- Captures result and carry, then returns them tagged with the requester ID.
- Sits between requesting blocks and the combinational datapath; the datapath is instantiated beside it, not inside it.

---
 rtl/addsub_alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_addsub_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_alu_arbiter.sv
// addsub_alu_arbiter: shares one external 4-bit add/sub datapath between two requesters.
// The winner's op/operands are latched onto alu_* and held for SETTLE_CYCLES cycles.
// After that window the datapath result is captured and returned tagged with the requester ID.
// Tie-breaking is round-robin by default.
// Define ARB_FIXED_PRIO_EN to make requester 0 always win a tie instead.

module addsub_alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    output logic       gnt0,

    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt1,

    output logic [1:0] alu_s,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_o,
    input  logic       alu_co,

    output logic [3:0] res_o,
    output logic       res_co,
    output logic       res_id,
    output logic       res_vld,
    output logic       busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_param_check
        $error("SETTLE_CYCLES must be in 1..15");
    end

    // The grant edge itself counts as the first settle cycle.
    localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_id_q, last_id_d;
    logic       win_q, win_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic [1:0] alu_s_q, alu_s_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] res_o_q, res_o_d;
    logic       res_co_q, res_co_d;
    logic       res_id_q, res_id_d;
    logic       res_vld_q, res_vld_d;

    logic any_req;
    logic pick1;

    assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
    // Requester 1 wins only when requester 0 is idle.
    assign pick1 = req1 & ~req0;
`else
    // On a tie, requester 1 wins only if requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last_id_q);
`endif

    // Next-state logic: arbitration in IDLE, settle countdown and capture in EXEC.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_id_d = last_id_q;
        win_d     = win_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        res_vld_d = 1'b0;
        alu_s_d   = alu_s_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        res_o_d   = res_o_q;
        res_co_d  = res_co_q;
        res_id_d  = res_id_q;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    win_d   = pick1;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    alu_s_d = pick1 ? op1 : op0;
                    alu_a_d = pick1 ? a1  : a0;
                    alu_b_d = pick1 ? b1  : b0;
                    cnt_d   = CntLoad;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_o_d   = alu_o;
                    res_co_d  = alu_co;
                    res_id_d  = win_q;
                    res_vld_d = 1'b1;
                    last_id_d = win_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset; last_id resets to 1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            last_id_q <= 1'b1;
            win_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            alu_s_q   <= 2'd0;
            alu_a_q   <= 4'd0;
            alu_b_q   <= 4'd0;
            res_o_q   <= 4'd0;
            res_co_q  <= 1'b0;
            res_id_q  <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_id_q <= last_id_d;
            win_q     <= win_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            alu_s_q   <= alu_s_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            res_o_q   <= res_o_d;
            res_co_q  <= res_co_d;
            res_id_q  <= res_id_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign alu_s   = alu_s_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign res_o   = res_o_q;
    assign res_co  = res_co_q;
    assign res_id  = res_id_q;
    assign res_vld = res_vld_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_addsub_alu_arbiter.sv
// Bench for addsub_alu_arbiter: directed vectors with a result scoreboard.
// A second instance runs with SETTLE_CYCLES=1 to check the minimum latency.

module tb_addsub_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic [1:0] alu_s;
    logic [3:0] alu_a, alu_b, alu_o;
    logic       alu_co;
    logic [3:0] res_o;
    logic       res_co, res_id, res_vld, busy;

    logic       s1_req0, s1_req1;
    logic [1:0] s1_op0, s1_op1;
    logic [3:0] s1_a0, s1_b0, s1_a1, s1_b1;
    logic       s1_gnt0, s1_gnt1;
    logic [1:0] s1_alu_s;
    logic [3:0] s1_alu_a, s1_alu_b, s1_alu_o;
    logic       s1_alu_co;
    logic [3:0] s1_res_o;
    logic       s1_res_co, s1_res_id, s1_res_vld, s1_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] o;
        logic       co;
        logic       id;
    } exp_t;

    exp_t sb_q[$];

    // Stand-in for the add/sub datapath: 00 add, 01 a+~b+1 (co = no borrow), 10 and, 11 or.
    function automatic logic [4:0] dp(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            2'b00:   dp = {1'b0, a} + {1'b0, b};
            2'b01:   dp = {1'b0, a} + {1'b0, ~b} + 5'd1;
            2'b10:   dp = {1'b0, a & b};
            default: dp = {1'b0, a | b};
        endcase
    endfunction

    assign {alu_co, alu_o}       = dp(alu_s, alu_a, alu_b);
    assign {s1_alu_co, s1_alu_o} = dp(s1_alu_s, s1_alu_a, s1_alu_b);

    addsub_alu_arbiter #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_co(alu_co),
        .res_o(res_o), .res_co(res_co), .res_id(res_id), .res_vld(res_vld), .busy(busy)
    );

    addsub_alu_arbiter #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .req0(s1_req0), .op0(s1_op0), .a0(s1_a0), .b0(s1_b0), .gnt0(s1_gnt0),
        .req1(s1_req1), .op1(s1_op1), .a1(s1_a1), .b1(s1_b1), .gnt1(s1_gnt1),
        .alu_s(s1_alu_s), .alu_a(s1_alu_a), .alu_b(s1_alu_b),
        .alu_o(s1_alu_o), .alu_co(s1_alu_co),
        .res_o(s1_res_o), .res_co(s1_res_co), .res_id(s1_res_id),
        .res_vld(s1_res_vld), .busy(s1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_exp(input logic [3:0] eo, input logic eco, input logic id);
        exp_t e;
        e.o  = eo;
        e.co = eco;
        e.id = id;
        sb_q.push_back(e);
    endtask

    // Monitor: every result pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (res_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL res_unexpected: got res_vld=1 res_o=%0d expected no result", res_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_res_o", 32'(res_o), 32'(e.o));
                chk("sb_res_co", 32'(res_co), 32'(e.co));
                chk("sb_res_id", 32'(res_id), 32'(e.id));
            end
        end
    end

    task automatic wait_gnt(output int who);
        who = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) begin
                n_checks++;
                n_fail++;
                $display("FAIL gnt_both: got gnt0=1 gnt1=1 expected one grant");
            end
            if (gnt0) begin
                who = 0;
                break;
            end
            if (gnt1) begin
                who = 1;
                break;
            end
        end
    endtask

    task automatic drive(input logic id, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b);
        if (id == 1'b0) begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end
    endtask

    // Single uncontended op: checks grant, latched alu_* inputs, busy window and capture edge.
    task automatic run_op(input logic id, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] eo, input logic eco);
        int who;
        push_exp(eo, eco, id);
        drive(id, op, a, b);
        wait_gnt(who);
        chk("op_gnt_id", 32'(who), 32'(id));
        chk("op_busy_e0", 32'(busy), 32'd1);
        chk("op_alu_s", 32'(alu_s), 32'(op));
        chk("op_alu_a", 32'(alu_a), 32'(a));
        chk("op_alu_b", 32'(alu_b), 32'(b));
        // Drop request and scramble operands; the op in flight must not change.
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b;
        @(negedge clk);
        chk("op_gnt_pulse", 32'({gnt0, gnt1}), 32'd0);
        chk("op_busy_e1", 32'(busy), 32'd1);
        chk("op_vld_early", 32'(res_vld), 32'd0);
        @(negedge clk);
        chk("op_vld_capture", 32'(res_vld), 32'd1);
        chk("op_busy_e2", 32'(busy), 32'd0);
        chk("op_alu_a_hold", 32'(alu_a), 32'(a));
    endtask

    logic [9:0] v0 [4];
    logic [9:0] v1 [4];
    int         exp_order [4];

    initial begin
        int who;
        int k0;
        int k1;

        rst_n = 1'b0;
        req0 = 1'b0; op0 = 2'd0; a0 = 4'd0; b0 = 4'd0;
        req1 = 1'b0; op1 = 2'd0; a1 = 4'd0; b1 = 4'd0;
        s1_req0 = 1'b0; s1_op0 = 2'd0; s1_a0 = 4'd0; s1_b0 = 4'd0;
        s1_req1 = 1'b0; s1_op1 = 2'd0; s1_a1 = 4'd0; s1_b1 = 4'd0;

        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_res", 32'({res_o, res_co, res_id}), 32'd0);
        chk("rst_alu", 32'({alu_s, alu_a, alu_b}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        run_op(1'b0, 2'b00, 4'd9,  4'd6, 4'd15, 1'b0);  // 9+6
        run_op(1'b1, 2'b00, 4'd10, 4'd6, 4'd0,  1'b1);  // 10+6 carries out
        run_op(1'b0, 2'b01, 4'd10, 4'd6, 4'd4,  1'b1);  // 10-6, no borrow
        run_op(1'b1, 2'b10, 4'd12, 4'd10, 4'd8, 1'b0);  // op 10 forwarded: 12&10
        run_op(1'b1, 2'b01, 4'd3,  4'd5, 4'd14, 1'b0);  // 3-5 borrows

        // Contention: both requesters held high; operands advance after each grant.
        v0[0] = {2'b00, 4'd1, 4'd2};  v0[1] = {2'b01, 4'd7, 4'd2};
        v0[2] = {2'b00, 4'd8, 4'd8};  v0[3] = {2'b00, 4'd5, 4'd5};
        v1[0] = {2'b00, 4'd3, 4'd4};  v1[1] = {2'b01, 4'd2, 4'd7};
        v1[2] = {2'b10, 4'd6, 4'd3};  v1[3] = {2'b11, 4'd9, 4'd6};
`ifdef ARB_FIXED_PRIO_EN
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
        push_exp(4'd3, 1'b0, 1'b0);
        push_exp(4'd5, 1'b1, 1'b0);
        push_exp(4'd0, 1'b1, 1'b0);
        push_exp(4'd10, 1'b0, 1'b0);
`else
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        push_exp(4'd3, 1'b0, 1'b0);
        push_exp(4'd7, 1'b0, 1'b1);
        push_exp(4'd5, 1'b1, 1'b0);
        push_exp(4'd11, 1'b0, 1'b1);
`endif
        k0 = 0;
        k1 = 0;
        req0 = 1'b1; {op0, a0, b0} = v0[0];
        req1 = 1'b1; {op1, a1, b1} = v1[0];
        for (int g = 0; g < 4; g++) begin
            wait_gnt(who);
            chk("contention_order", 32'(who), 32'(exp_order[g]));
            if (who == 0 && k0 < 3) begin
                k0++;
                {op0, a0, b0} = v0[k0];
            end else if (who == 1 && k1 < 3) begin
                k1++;
                {op1, a1, b1} = v1[k1];
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("contention_drained", 32'(sb_q.size()), 32'd0);

        // Make requester 0 the last served, then abort an op with reset.
        run_op(1'b0, 2'b00, 4'd1, 4'd1, 4'd2, 1'b0);
        drive(1'b1, 2'b00, 4'd2, 4'd3);
        wait_gnt(who);
        chk("abort_gnt_id", 32'(who), 32'd1);
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 4'd4, 4'd4);
        drive(1'b1, 2'b00, 4'd6, 4'd6);
        push_exp(4'd8, 1'b0, 1'b0);
        push_exp(4'd12, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_res_vld", 32'(res_vld), 32'd0);
        chk("abort_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("abort_res", 32'({res_o, res_co, res_id}), 32'd0);
        chk("abort_alu", 32'({alu_s, alu_a, alu_b}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_gnt(who);
        chk("post_reset_first", 32'(who), 32'd0);
        req0 = 1'b0;
        wait_gnt(who);
        chk("post_reset_second", 32'(who), 32'd1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Request raised during EXEC waits until the FSM is back in IDLE.
        push_exp(4'd4, 1'b0, 1'b0);
        push_exp(4'd5, 1'b1, 1'b1);
        drive(1'b0, 2'b00, 4'd2, 4'd2);
        wait_gnt(who);
        chk("busy_rej_first", 32'(who), 32'd0);
        req0 = 1'b0;
        drive(1'b1, 2'b01, 4'd9, 4'd4);
        @(negedge clk);
        chk("busy_rej_e1", 32'(gnt1), 32'd0);
        @(negedge clk);
        chk("busy_rej_e2", 32'(gnt1), 32'd0);
        chk("busy_rej_vld", 32'(res_vld), 32'd1);
        @(negedge clk);
        chk("busy_rej_grant", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // SETTLE_CYCLES=1: capture on the edge right after the grant.
        s1_req0 = 1'b1; s1_op0 = 2'b00; s1_a0 = 4'd7; s1_b0 = 4'd7;
        who = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s1_gnt0) begin
                who = 0;
                break;
            end
        end
        chk("s1_gnt", 32'(who), 32'd0);
        chk("s1_busy", 32'(s1_busy), 32'd1);
        s1_req0 = 1'b0;
        @(negedge clk);
        chk("s1_vld", 32'(s1_res_vld), 32'd1);
        chk("s1_res_o", 32'(s1_res_o), 32'd14);
        chk("s1_res_co_id", 32'({s1_res_co, s1_res_id}), 32'd0);
        chk("s1_busy_done", 32'(s1_busy), 32'd0);

        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
